// File: rtl/adc_readout_arbiter_pkg.sv
// Shared types and constants for the ADC readout arbiter: FSM state encoding
// and the width of the grant index.
package adc_readout_arbiter_pkg;

  localparam int GRANT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

endpackage

// File: rtl/adc_arb_rr_pick.sv
// Rotating-priority picker: returns the first set request bit found by
// searching cyclically upward from last+1.
module adc_arb_rr_pick
  import adc_readout_arbiter_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]    req,
  input  logic [GRANT_W-1:0] last,
  output logic [GRANT_W-1:0] idx,
  output logic               any
);

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    int c;
    c   = 0;
    idx = last;
    any = 1'b0;
    for (int k = N_CH; k >= 1; k--) begin
      c = (int'(last) + k) % N_CH;
      if ((req & (N_CH'(1) << c)) != '0) begin
        idx = GRANT_W'(c);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_readout_arbiter.sv
// Round-robin burst arbiter merging N_CH channel FIFOs into one FWFT stream
// through a single output register.
module adc_readout_arbiter
  import adc_readout_arbiter_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int BURST = 16,
  parameter int DW    = 32
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  input  logic [N_CH-1:0]      CH_EN,
  input  logic [N_CH-1:0]      CH_FIFO_EMPTY,
  input  logic [N_CH*DW-1:0]   CH_FIFO_DATA,
  output logic [N_CH-1:0]      CH_FIFO_READ,
  input  logic                 FIFO_READ,
  output logic                 FIFO_EMPTY,
  output logic [DW-1:0]        FIFO_DATA,
  output logic [GRANT_W-1:0]   GRANT,
  output logic                 BUSY
);

  localparam int CW = $clog2(BURST + 1);

  state_e             state_q;
  logic [GRANT_W-1:0] grant_q;
  logic [CW-1:0]      cnt_q;
  logic               valid_q;
  logic [DW-1:0]      data_q;

  logic [N_CH-1:0]    req;
  logic [N_CH-1:0]    gmask;
  logic               ch_ok;
  logic               out_free;
  logic               xfer;
  logic               burst_done;
  logic [DW-1:0]      ch_word;
  logic [GRANT_W-1:0] pick_idx;
  logic               pick_any;

  assign req        = CH_EN & ~CH_FIFO_EMPTY;
  assign gmask      = N_CH'(1) << grant_q;
  assign ch_ok      = |(gmask & req);
  assign out_free   = ~valid_q | FIFO_READ;
  assign xfer       = (state_q == ST_XFER) && ch_ok && out_free;
  assign burst_done = (cnt_q == CW'(BURST - 1));

  assign CH_FIFO_READ = xfer ? gmask : '0;
  assign FIFO_EMPTY   = ~valid_q;
  assign FIFO_DATA    = data_q;
  assign GRANT        = grant_q;
  assign BUSY         = (state_q == ST_XFER);

  always_comb begin
    ch_word = '0;
    for (int i = 0; i < N_CH; i++)
      if (grant_q == GRANT_W'(i)) ch_word = CH_FIFO_DATA[i*DW +: DW];
  end

  adc_arb_rr_pick #(.N_CH(N_CH)) u_pick (
    .req  (req),
    .last (grant_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q <= ST_IDLE;
      grant_q <= GRANT_W'(N_CH - 1);
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      // A read with a simultaneous transfer swaps the word; valid stays set.
      if (xfer) begin
        data_q  <= ch_word;
        valid_q <= 1'b1;
      end else if (FIFO_READ) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: if (|req) state_q <= ST_SEL;
        ST_SEL: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            cnt_q   <= '0;
            state_q <= ST_XFER;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_XFER: begin
          // Sink backpressure alone never ends the grant; only count or source loss.
          if (xfer) begin
            cnt_q <= cnt_q + CW'(1);
            if (burst_done) state_q <= (|req) ? ST_SEL : ST_IDLE;
          end else if (!ch_ok) begin
            state_q <= (|req) ? ST_SEL : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_readout_arbiter.sv
// Directed bench for adc_readout_arbiter: table of round-robin scenarios plus
// hand-written latency, backpressure, disable and reset sequences.
`timescale 1ns/1ps
module tb_adc_readout_arbiter;

  localparam int N_CH  = 4;
  localparam int BURST = 8;
  localparam int DW    = 32;

  logic                BUS_CLK = 1'b0;
  logic                BUS_RST_N = 1'b1;
  logic [N_CH-1:0]     CH_EN = '0;
  logic [N_CH-1:0]     CH_FIFO_EMPTY = '1;
  logic [N_CH*DW-1:0]  CH_FIFO_DATA = '0;
  logic [N_CH-1:0]     CH_FIFO_READ;
  logic                FIFO_READ = 1'b0;
  logic                FIFO_EMPTY;
  logic [DW-1:0]       FIFO_DATA;
  logic [2:0]          GRANT;
  logic                BUSY;

  always #5 BUS_CLK = ~BUS_CLK;

  adc_readout_arbiter #(.N_CH(N_CH), .BURST(BURST), .DW(DW)) dut (
    .BUS_CLK       (BUS_CLK),
    .BUS_RST_N     (BUS_RST_N),
    .CH_EN         (CH_EN),
    .CH_FIFO_EMPTY (CH_FIFO_EMPTY),
    .CH_FIFO_DATA  (CH_FIFO_DATA),
    .CH_FIFO_READ  (CH_FIFO_READ),
    .FIFO_READ     (FIFO_READ),
    .FIFO_EMPTY    (FIFO_EMPTY),
    .FIFO_DATA     (FIFO_DATA),
    .GRANT         (GRANT),
    .BUSY          (BUSY)
  );

  typedef struct packed {
    logic [3:0]      en;
    logic [3:0][7:0] n;       // words preloaded per channel
    logic [3:0]      nb;      // expected number of bursts
    logic [7:0][7:0] bursts;  // {ch[7:4], len[3:0]}, first burst in byte 0
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] src[N_CH][$];
  logic [DW-1:0] inflight[$];
  int            b_ch[$];
  int            b_len[$];
  int            popped[N_CH];
  int            n_out;

  logic [N_CH-1:0] snap_rd = '0;
  logic [N_CH-1:0] prev_rd = '0;
  logic            snap_take = 1'b0;
  logic [DW-1:0]   snap_word = '0;

  always @(posedge BUS_CLK) begin
    snap_rd   <= CH_FIFO_READ;
    snap_take <= FIFO_READ && !FIFO_EMPTY;
    snap_word <= FIFO_DATA;
  end

  function automatic logic [DW-1:0] mkw(input int ch, input int k);
    return 32'hD000_0000 | (ch << 16) | k;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N_CH; i++) begin
      CH_FIFO_EMPTY[i] = (src[i].size() == 0);
      CH_FIFO_DATA[i*DW +: DW] = (src[i].size() == 0) ? '0 : src[i][0];
    end
  endtask

  // One clock: account for what happened at the edge, then update the sources.
  task automatic cyc();
    logic [DW-1:0] w;
    @(posedge BUS_CLK);
    @(negedge BUS_CLK);
    if (snap_take) begin
      check("out_has_word", inflight.size() != 0, 1);
      if (inflight.size() != 0) begin
        w = inflight.pop_front();
        check("out_word", snap_word, w);
      end
      n_out++;
    end
    if (snap_rd != '0) begin
      check("rd_onehot", $onehot(snap_rd), 1);
      for (int i = 0; i < N_CH; i++) begin
        if (snap_rd[i]) begin
          check("rd_nonempty", src[i].size() != 0, 1);
          if (src[i].size() != 0) begin
            w = src[i].pop_front();
            inflight.push_back(w);
            popped[i]++;
          end
          if (snap_rd == prev_rd) begin
            b_len[b_len.size()-1] = b_len[b_len.size()-1] + 1;
          end else begin
            b_ch.push_back(i);
            b_len.push_back(1);
          end
        end
      end
    end
    prev_rd = snap_rd;
    refresh();
  endtask

  task automatic clear_logs();
    inflight.delete();
    b_ch.delete();
    b_len.delete();
    prev_rd = '0;
    n_out = 0;
    for (int i = 0; i < N_CH; i++) popped[i] = 0;
  endtask

  task automatic do_reset();
    BUS_RST_N = 1'b0;
    CH_EN     = '0;
    FIFO_READ = 1'b0;
    for (int i = 0; i < N_CH; i++) src[i].delete();
    refresh();
    repeat (2) @(negedge BUS_CLK);
    clear_logs();
    BUS_RST_N = 1'b1;
  endtask

  vec_t vt[6];

  initial begin
    int rem;
    int tot;
    bit started;

    vt[0] = '{en: 4'b0001, n: 32'h0000_0005, nb: 4'd1, bursts: 64'h05};
    vt[1] = '{en: 4'b1111, n: 32'h0A0A_0A0A, nb: 4'd8, bursts: 64'h3222_1202_3828_1808};
    vt[2] = '{en: 4'b1010, n: 32'h0303_0303, nb: 4'd2, bursts: 64'h3313};
    vt[3] = '{en: 4'b1000, n: 32'h1400_0000, nb: 4'd3, bursts: 64'h34_3838};
    vt[4] = '{en: 4'b1111, n: 32'h0900_0200, nb: 4'd3, bursts: 64'h31_3812};
    vt[5] = '{en: 4'b0110, n: 32'h0404_0004, nb: 4'd1, bursts: 64'h24};

    // Reset values and single-channel latency
    do_reset();
    check("rst_ch_read", CH_FIFO_READ, 4'b0000);
    check("rst_empty", FIFO_EMPTY, 1);
    check("rst_data", FIFO_DATA, 0);
    check("rst_grant", GRANT, 3);
    check("rst_busy", BUSY, 0);
    for (int k = 0; k < 5; k++) src[0].push_back(32'hA0 + k);
    CH_EN = 4'b0001;
    FIFO_READ = 1'b1;
    refresh();
    cyc();
    check("lat_sel_busy", BUSY, 0);
    check("lat_sel_empty", FIFO_EMPTY, 1);
    cyc();
    check("lat_xfer_busy", BUSY, 1);
    check("lat_xfer_grant", GRANT, 0);
    check("lat_first_read", CH_FIFO_READ, 4'b0001);
    check("lat_xfer_empty", FIFO_EMPTY, 1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      check($sformatf("lat_data%0d", k), FIFO_DATA, 32'hA0 + k);
      check($sformatf("lat_valid%0d", k), FIFO_EMPTY, 0);
    end
    check("lat_busy_hold", BUSY, 1);
    cyc();
    check("lat_busy_drop", BUSY, 0);
    check("lat_drained", FIFO_EMPTY, 1);

    // Table-driven round-robin scenarios, sink always reading
    for (int t = 0; t < 6; t++) begin
      do_reset();
      tot = 0;
      for (int ch = 0; ch < N_CH; ch++)
        for (int k = 0; k < int'(vt[t].n[ch]); k++) src[ch].push_back(mkw(ch, k));
      CH_EN = vt[t].en;
      FIFO_READ = 1'b1;
      refresh();
      repeat (120) cyc();
      check($sformatf("t%0d_nbursts", t), b_ch.size(), vt[t].nb);
      for (int b = 0; b < int'(vt[t].nb); b++) begin
        tot += int'(vt[t].bursts[b][3:0]);
        if (b < b_ch.size()) begin
          check($sformatf("t%0d_b%0d_ch", t, b), b_ch[b], vt[t].bursts[b][7:4]);
          check($sformatf("t%0d_b%0d_len", t, b), b_len[b], vt[t].bursts[b][3:0]);
        end
      end
      for (int ch = 0; ch < N_CH; ch++) begin
        rem = int'(vt[t].n[ch]);
        for (int b = 0; b < int'(vt[t].nb); b++)
          if (int'(vt[t].bursts[b][7:4]) == ch) rem -= int'(vt[t].bursts[b][3:0]);
        check($sformatf("t%0d_rem_ch%0d", t, ch), src[ch].size(), rem);
      end
      check($sformatf("t%0d_delivered", t), n_out, tot);
      check($sformatf("t%0d_inflight", t), inflight.size(), 0);
    end

    // Backpressure: sink read toggles every cycle
    do_reset();
    for (int k = 0; k < 6; k++) src[0].push_back(mkw(0, k));
    CH_EN = 4'b0001;
    refresh();
    started = 0;
    for (int k = 0; k < 40; k++) begin
      FIFO_READ = k[0];
      #1;
      if (CH_FIFO_READ != '0) check("bp_reg_free", FIFO_EMPTY | FIFO_READ, 1);
      cyc();
      if (started && src[0].size() != 0) check("bp_grant_held", BUSY, 1);
      if (BUSY) started = 1;
    end
    FIFO_READ = 1'b1;
    repeat (4) cyc();
    check("bp_delivered", n_out, 6);
    check("bp_src_empty", src[0].size(), 0);
    check("bp_inflight", inflight.size(), 0);

    // Channel disabled mid-burst
    do_reset();
    for (int k = 0; k < 8; k++) src[1].push_back(mkw(1, k));
    for (int k = 0; k < 3; k++) src[2].push_back(mkw(2, k));
    CH_EN = 4'b1111;
    FIFO_READ = 1'b1;
    refresh();
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (popped[1] == 2) break;
    end
    check("dis_reached_two", popped[1], 2);
    CH_EN = 4'b1101;
    repeat (30) cyc();
    check("dis_nbursts", b_ch.size(), 2);
    if (b_ch.size() >= 2) begin
      check("dis_b0_ch", b_ch[0], 1);
      check("dis_b0_len", b_len[0], 2);
      check("dis_b1_ch", b_ch[1], 2);
      check("dis_b1_len", b_len[1], 3);
    end
    check("dis_ch1_left", src[1].size(), 6);
    if (src[1].size() != 0) check("dis_ch1_head", src[1][0], mkw(1, 2));
    check("dis_delivered", n_out, 5);

    // Reset asserted mid-burst with a word held in the output register
    do_reset();
    for (int k = 0; k < 10; k++) src[0].push_back(mkw(0, k));
    for (int k = 0; k < 5; k++) src[2].push_back(mkw(2, k));
    CH_EN = 4'b1111;
    FIFO_READ = 1'b1;
    refresh();
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (popped[0] >= 3) break;
    end
    check("rmb_pre_busy", BUSY, 1);
    check("rmb_pre_valid", FIFO_EMPTY, 0);
    BUS_RST_N = 1'b0;
    #1;
    check("rmb_empty", FIFO_EMPTY, 1);
    check("rmb_grant", GRANT, 3);
    check("rmb_busy", BUSY, 0);
    check("rmb_ch_read", CH_FIFO_READ, 4'b0000);
    check("rmb_data", FIFO_DATA, 0);
    @(posedge BUS_CLK);
    @(negedge BUS_CLK);
    clear_logs();
    BUS_RST_N = 1'b1;
    repeat (40) cyc();
    check("rmb_nbursts", b_ch.size(), 2);
    if (b_ch.size() >= 2) begin
      check("rmb_first_grant", b_ch[0], 0);
      check("rmb_first_len", b_len[0], 7);
      check("rmb_second_grant", b_ch[1], 2);
    end
    check("rmb_ch0_drained", src[0].size(), 0);
    check("rmb_ch2_drained", src[2].size(), 0);
    check("rmb_delivered", n_out, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
